can_crc_rx_check: RTL and testbench
===================================

Name: can_crc_rx_check

Overview:
- Receive-side CAN 2.0 CRC-15 checker. Sits after the bit destuffer in the CAN receiver.
- Recomputes CRC-15 over destuffed bits from SOF through the end of the data field.
- Captures the received 15-bit CRC field and samples the CRC delimiter.
- Reports match, mismatch and delimiter form error to the receive controller.

Parameters:
- CRC_W, 15, CRC width in bits.
- CRC_POLY, 15'h4599, CAN generator polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1, with x^15 implied.
- CRC_INIT, 15'h0000, LFSR value at SOF.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  1  destuffed serial bit, MSB first; 0 = dominant
- bit_en  in  1  qualifies din; one-cycle strobe per nominal bit
- sof  in  1  with bit_en, marks the SOF bit; SOF is included in the CRC
- crc_start  in  1  with bit_en, marks the first bit of the CRC field
- abort  in  1  synchronous; return to IDLE (error frame, bus-off)
- busy  out  1  high in any state other than IDLE
- crc_calc  out  15  computed CRC; holds the final value after the last data bit
- crc_rx  out  15  received CRC field
- done  out  1  one-cycle pulse when the delimiter has been evaluated
- crc_ok  out  1  sticky; CRC matches and delimiter is recessive
- crc_err  out  1  sticky; crc_rx != crc_calc
- delim_err  out  1  sticky; CRC delimiter sampled dominant

Behaviour:
- Reset: state=IDLE; LFSR, crc_rx and bit counter = 0; busy, done, crc_ok, crc_err, delim_err = 0.
- LFSR step on each accepted bit:
  - nxt = din ^ lfsr[14]
  - lfsr <= {lfsr[13:0],1'b0} ^ (nxt ? CRC_POLY : 0)
- All state changes happen only on cycles with bit_en=1, except abort and reset.
- Outputs are registered; each accepted bit is visible the cycle after its bit_en.
- FSM states: IDLE, CALC, RXCRC, DELIM.
- IDLE:
  - bit_en&sof: lfsr <= step(CRC_INIT, din); clear crc_rx, crc_ok, crc_err, delim_err; go to CALC.
  - Other bits, including crc_start, are ignored.
- CALC:
  - bit_en & !crc_start: LFSR step.
  - bit_en & crc_start: LFSR frozen; crc_rx <= {14'b0,din}; cnt=1; go to RXCRC.
- RXCRC:
  - bit_en: crc_rx <= {crc_rx[13:0],din}; cnt++.
  - When the 15th CRC bit is taken (cnt reaches 15), go to DELIM.
- DELIM:
  - bit_en: done=1 for exactly one clk.
  - crc_err = (crc_rx != crc_calc); delim_err = (din==0); crc_ok = !crc_err & !delim_err.
  - Go to IDLE.
- Sticky flags hold until the next accepted sof or abort.
- Priority: abort > sof > crc_start > plain bit.
  - abort in any state: go to IDLE; clear flags; no done; crc_calc and crc_rx hold.
  - sof with bit_en in CALC, RXCRC or DELIM: restart as from IDLE (resync); no done for the truncated frame.
  - crc_start in RXCRC or DELIM is ignored; the bit is treated as a normal bit.
- Zero data bits (crc_start on the bit right after SOF) is legal; crc_calc is the CRC of the SOF bit only.
- Reset mid-frame: immediate return to reset values; no done.
- Widths: cnt is 4 bits, range 0..15, and never wraps; crc_calc is 15 bits and the x^15 term is dropped.

Decomposition:
- Package can_pkg holds:
  - CAN_CRC_W = 15, CAN_CRC_POLY = 15'h4599, CAN_CRC_INIT = 15'h0000
  - 2-bit state encoding: IDLE=0, CALC=1, RXCRC=2, DELIM=3
  - the CRC-15 step function, shared with the transmit-side generator
- One sub-module is natural: can_crc15_lfsr (serial LFSR with enable and synchronous load-init). It is instantiated here and is reusable by the TX path.
- The FSM, crc_rx shifter and compare stay in the top module.

Test Plan:
- Match:
  - Stimulus: SOF=0, data bit 1, crc_start with CRC 15'h4599 sent MSB first (100010110011001), delimiter 1.
  - Response: crc_calc=15'h4599, crc_rx=15'h4599, done pulse, crc_ok=1, crc_err=0, delim_err=0.
- Mismatch:
  - Stimulus: SOF=0, data bits 1,1, CRC field 15'h4599, delimiter 1.
  - Response: crc_calc=15'h0B32, crc_err=1, crc_ok=0, done pulse.
- Delimiter error:
  - Stimulus: same as the match case but delimiter 0.
  - Response: crc_err=0, delim_err=1, crc_ok=0.
- Gapped bit_en:
  - Stimulus: the match case with 0-7 idle clks between bit_en strobes, and din toggling while bit_en=0.
  - Response: identical results to the match case; done occurs exactly once.
- Abort/resync:
  - Stimulus: abort during RXCRC at cnt=7. Then run a fresh match frame, and in it issue sof again mid-CALC.
  - Response: after abort, busy=0 next clk, no done, flags 0. After the mid-CALC sof, the CRC restarts and only the second frame gives done with crc_ok=1.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 asynchronously in DELIM.
  - Response: all outputs 0 immediately, no done; the next frame checks correctly.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN CRC-15 definitions: constants, receive-checker state encoding and
// the serial CRC step used by both the receive checker and the transmit generator.
package can_pkg;

  localparam int              CAN_CRC_W    = 15;
  localparam logic [14:0]     CAN_CRC_POLY = 15'h4599;
  localparam logic [14:0]     CAN_CRC_INIT = 15'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_RXCRC = 2'd2,
    ST_DELIM = 2'd3
  } can_crc_state_e;

  // One serial CRC step; the x^15 term is implicit and drops out of the shift.
  function automatic logic [CAN_CRC_W-1:0] can_crc15_step(
    input logic [CAN_CRC_W-1:0] crc,
    input logic                 din,
    input logic [CAN_CRC_W-1:0] poly
  );
    logic nxt;
    nxt = din ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (nxt ? poly : '0);
  endfunction

endpackage

// File: rtl/can_crc15_lfsr.sv
// Serial CAN CRC-15 LFSR with bit enable and a synchronous load that seeds
// from INIT and absorbs the loading bit in the same cycle.
module can_crc15_lfsr
  import can_pkg::*;
#(
  parameter int             W    = CAN_CRC_W,
  parameter logic [W-1:0]   POLY = CAN_CRC_POLY,
  parameter logic [W-1:0]   INIT = CAN_CRC_INIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic         i_din,
  output logic [W-1:0] o_crc
);

  logic [W-1:0] r_lfsr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= can_crc15_step(INIT, i_din, POLY);
    end else if (i_en) begin
      r_lfsr <= can_crc15_step(r_lfsr, i_din, POLY);
    end
  end

  assign o_crc = r_lfsr;

endmodule

// File: rtl/can_crc_rx_check.sv
// Receive-side CAN CRC-15 checker: recomputes the CRC from SOF to end of data,
// captures the received CRC field and evaluates the CRC delimiter.
module can_crc_rx_check
  import can_pkg::*;
#(
  parameter int                 CRC_W    = CAN_CRC_W,
  parameter logic [CRC_W-1:0]   CRC_POLY = CAN_CRC_POLY,
  parameter logic [CRC_W-1:0]   CRC_INIT = CAN_CRC_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             bit_en,
  input  logic             sof,
  input  logic             crc_start,
  input  logic             abort,
  output logic             busy,
  output logic [CRC_W-1:0] crc_calc,
  output logic [CRC_W-1:0] crc_rx,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             delim_err
);

  can_crc_state_e   r_state;
  can_crc_state_e   w_state_nxt;
  logic             w_lfsr_load;
  logic             w_lfsr_en;
  logic [CRC_W-1:0] w_crc_calc;
  logic [CRC_W-1:0] r_crc_rx;
  logic [3:0]       r_cnt;
  logic             r_done;
  logic             r_crc_ok;
  logic             r_crc_err;
  logic             r_delim_err;

  can_crc15_lfsr #(
    .W    (CRC_W),
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_lfsr_en),
    .i_load (w_lfsr_load),
    .i_din  (din),
    .o_crc  (w_crc_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_load = 1'b0;
    w_lfsr_en   = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else if (bit_en) begin
      if (sof) begin
        w_state_nxt = ST_CALC;
        w_lfsr_load = 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE:  w_state_nxt = ST_IDLE;
          ST_CALC: begin
            if (crc_start) w_state_nxt = ST_RXCRC;
            else           w_lfsr_en   = 1'b1;
          end
          ST_RXCRC: begin
            if (r_cnt == 4'(CRC_W - 1)) w_state_nxt = ST_DELIM;
          end
          ST_DELIM: w_state_nxt = ST_IDLE;
          default:  w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // crc_calc and crc_rx hold across abort so the controller can still inspect them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_rx    <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_err   <= 1'b0;
      r_delim_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_cnt       <= '0;
        r_crc_ok    <= 1'b0;
        r_crc_err   <= 1'b0;
        r_delim_err <= 1'b0;
      end else if (bit_en) begin
        if (sof) begin
          r_crc_rx    <= '0;
          r_cnt       <= '0;
          r_crc_ok    <= 1'b0;
          r_crc_err   <= 1'b0;
          r_delim_err <= 1'b0;
        end else begin
          unique case (r_state)
            ST_CALC: begin
              if (crc_start) begin
                r_crc_rx <= {{(CRC_W-1){1'b0}}, din};
                r_cnt    <= 4'd1;
              end
            end
            ST_RXCRC: begin
              r_crc_rx <= {r_crc_rx[CRC_W-2:0], din};
              r_cnt    <= r_cnt + 4'd1;
            end
            ST_DELIM: begin
              r_done      <= 1'b1;
              r_crc_err   <= (r_crc_rx != w_crc_calc);
              r_delim_err <= ~din;
              r_crc_ok    <= (r_crc_rx == w_crc_calc) & din;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign crc_calc  = w_crc_calc;
  assign crc_rx    = r_crc_rx;
  assign done      = r_done;
  assign crc_ok    = r_crc_ok;
  assign crc_err   = r_crc_err;
  assign delim_err = r_delim_err;

endmodule

// File: tb/tb_can_crc_rx_check.sv
// Self-checking bench for can_crc_rx_check; the reference CRC is computed as the
// GF(2) polynomial remainder of message * x^15 divided by the CAN generator.
module tb_can_crc_rx_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din, bit_en, sof, crc_start, abort;
  logic        busy, done, crc_ok, crc_err, delim_err;
  logic [14:0] crc_calc, crc_rx;

  int errors = 0;
  int checks = 0;
  int done_total = 0;

  can_crc_rx_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .bit_en    (bit_en),
    .sof       (sof),
    .crc_start (crc_start),
    .abort     (abort),
    .busy      (busy),
    .crc_calc  (crc_calc),
    .crc_rx    (crc_rx),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .delim_err (delim_err)
  );

  always #5 clk = ~clk;

  // Counts clocks on which done is high; a stretched pulse counts more than once.
  always @(posedge clk) begin
    #2;
    if (done === 1'b1) done_total++;
  end

  // Long division of msg(x)*x^15 by G(x) = x^15 + 0x4599 over GF(2).
  function automatic logic [14:0] ref_crc(input bit msg[$]);
    bit          work[$];
    bit [15:0]   gen;
    logic [14:0] rem;
    gen  = 16'hC599;
    work = msg;
    for (int i = 0; i < 15; i++) work.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (work[i])
        for (int j = 0; j < 16; j++) work[i+j] = work[i+j] ^ gen[15-j];
    for (int i = 0; i < 15; i++) rem[14-i] = work[msg.size()+i];
    return rem;
  endfunction

  task automatic send_bit(input bit d, input bit s, input bit c, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      din = 1'($urandom);
    end
    @(negedge clk);
    din = d; sof = s; crc_start = c; bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0; sof = 1'b0; crc_start = 1'($urandom); din = 1'($urandom);
  endtask

  // msg[0] is the SOF bit; returns at the negedge after the delimiter was accepted.
  task automatic send_frame(input bit msg[$], input logic [14:0] crc, input bit delim,
                            input int maxgap, input bit start_noise);
    send_bit(msg[0], 1'b1, 1'b0, maxgap);
    for (int i = 1; i < msg.size(); i++) send_bit(msg[i], 1'b0, 1'b0, maxgap);
    for (int i = 14; i >= 0; i--)
      send_bit(crc[i], 1'b0, (i == 14) ? 1'b1 : (start_noise & 1'($urandom)), maxgap);
    send_bit(delim, 1'b0, start_noise & 1'($urandom), maxgap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 0; bit_en = 0; sof = 0; crc_start = 0; abort = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, crc_calc, crc_rx, done, crc_ok, crc_err, delim_err} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b calc=%h rx=%h done=%b ok=%b err=%b derr=%b, want all 0",
               busy, crc_calc, crc_rx, done, crc_ok, crc_err, delim_err);
    end
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0, 1'b1, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_crc_start: busy=%b want 0", busy);
    end
  endtask

  task automatic test_match();
    bit   msg[$];
    int   d0;
    msg = '{1'b0, 1'b1};
    d0  = done_total;
    send_frame(msg, 15'h4599, 1'b1, 0, 1'b0);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL match_done_timing: done=%b want 1", done); end
    checks++;
    if (crc_calc !== 15'h4599 || crc_calc !== ref_crc(msg)) begin
      errors++; $display("FAIL match_crc_calc: got %h want %h", crc_calc, ref_crc(msg));
    end
    checks++;
    if (crc_rx !== 15'h4599) begin errors++; $display("FAIL match_crc_rx: got %h want 4599", crc_rx); end
    checks++;
    if ({crc_ok, crc_err, delim_err} !== 3'b100) begin
      errors++; $display("FAIL match_flags: ok/err/derr=%b want 100", {crc_ok, crc_err, delim_err});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_total - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL match_done_once: done=%b pulses=%0d busy=%b want 0/1/0", done, done_total - d0, busy);
    end
    checks++;
    if (crc_ok !== 1'b1) begin errors++; $display("FAIL match_sticky: crc_ok=%b want 1", crc_ok); end
  endtask

  task automatic test_mismatch();
    bit msg[$];
    int d0;
    msg = '{1'b0, 1'b1, 1'b1};
    d0  = done_total;
    send_frame(msg, 15'h4599, 1'b1, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (crc_calc !== 15'h0B32 || crc_calc !== ref_crc(msg)) begin
      errors++; $display("FAIL mismatch_crc_calc: got %h want 0b32", crc_calc);
    end
    checks++;
    if ({crc_ok, crc_err, delim_err} !== 3'b010 || done_total - d0 != 1) begin
      errors++; $display("FAIL mismatch_flags: ok/err/derr=%b pulses=%0d want 010/1",
                         {crc_ok, crc_err, delim_err}, done_total - d0);
    end
  endtask

  task automatic test_delim_err();
    bit msg[$];
    msg = '{1'b0, 1'b1};
    send_frame(msg, 15'h4599, 1'b0, 0, 1'b0);
    checks++;
    if ({crc_ok, crc_err, delim_err} !== 3'b001) begin
      errors++; $display("FAIL delim_err_flags: ok/err/derr=%b want 001", {crc_ok, crc_err, delim_err});
    end
  endtask

  task automatic test_gapped();
    bit msg[$];
    int d0;
    msg = '{1'b0, 1'b1};
    d0  = done_total;
    send_frame(msg, 15'h4599, 1'b1, 7, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (crc_calc !== 15'h4599 || crc_rx !== 15'h4599 || {crc_ok, crc_err, delim_err} !== 3'b100) begin
      errors++; $display("FAIL gapped_result: calc=%h rx=%h ok/err/derr=%b want 4599/4599/100",
                         crc_calc, crc_rx, {crc_ok, crc_err, delim_err});
    end
    checks++;
    if (done_total - d0 != 1) begin
      errors++; $display("FAIL gapped_done_count: got %0d want 1", done_total - d0);
    end
  endtask

  task automatic test_abort_resync();
    bit msg[$];
    int d0;
    msg = '{1'b0, 1'b1};
    send_frame(msg, 15'h4599, 1'b1, 0, 1'b0);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (crc_ok !== 1'b0 || crc_calc !== 15'h4599) begin
      errors++; $display("FAIL abort_clears_flags: crc_ok=%b calc=%h want 0/4599", crc_ok, crc_calc);
    end
    d0 = done_total;
    send_bit(1'b0, 1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 1'b0, 0);
    for (int i = 14; i >= 8; i--) send_bit(15'h4599 >> i, 1'b0, (i == 14), 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: busy=%b want 1", busy); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || {crc_ok, crc_err, delim_err} !== 3'b000 || crc_rx !== 15'h0045 ||
        crc_calc !== 15'h4599) begin
      errors++; $display("FAIL abort_state: busy=%b flags=%b rx=%h calc=%h want 0/000/0045/4599",
                         busy, {crc_ok, crc_err, delim_err}, crc_rx, crc_calc);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_total != d0) begin errors++; $display("FAIL abort_no_done: pulses=%0d want 0", done_total - d0); end
    d0 = done_total;
    send_bit(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0, 1'b0, 0);
    send_frame(msg, 15'h4599, 1'b1, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (done_total - d0 != 1 || crc_ok !== 1'b1 || crc_calc !== 15'h4599) begin
      errors++; $display("FAIL resync_result: pulses=%0d ok=%b calc=%h want 1/1/4599",
                         done_total - d0, crc_ok, crc_calc);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit msg[$];
    int d0;
    msg = '{1'b0, 1'b1};
    d0  = done_total;
    send_bit(1'b0, 1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 1'b0, 0);
    for (int i = 14; i >= 0; i--) send_bit(15'h4599 >> i, 1'b0, (i == 14), 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, crc_calc, crc_rx, done, crc_ok, crc_err, delim_err} !== 35'h0) begin
      errors++; $display("FAIL reset_mid_frame: busy=%b calc=%h rx=%h done=%b flags=%b want all 0",
                         busy, crc_calc, crc_rx, done, {crc_ok, crc_err, delim_err});
    end
    @(negedge clk); rst_n = 1'b1;
    send_frame(msg, 15'h4599, 1'b1, 2, 1'b0);
    @(negedge clk);
    checks++;
    if (done_total - d0 != 1 || crc_ok !== 1'b1) begin
      errors++; $display("FAIL reset_then_frame: pulses=%0d ok=%b want 1/1", done_total - d0, crc_ok);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit          msg[$];
      int          len, d0;
      logic [14:0] exp_crc, sent;
      bit          delim, good;
      msg.delete();
      msg.push_back(1'b0);
      len = int'($urandom_range(20, 0));
      for (int i = 0; i < len; i++) msg.push_back(1'($urandom));
      exp_crc = ref_crc(msg);
      sent    = ($urandom_range(2, 0) == 0) ? 15'($urandom) : exp_crc;
      delim   = ($urandom_range(3, 0) != 0);
      good    = (sent == exp_crc) && delim;
      d0      = done_total;
      send_frame(msg, sent, delim, 3, 1'b1);
      @(negedge clk);
      checks++;
      if (crc_calc !== exp_crc || crc_rx !== sent) begin
        errors++; $display("FAIL random_%0d_crc: calc=%h rx=%h want %h/%h", n, crc_calc, crc_rx, exp_crc, sent);
      end
      checks++;
      if ({crc_ok, crc_err, delim_err} !== {good, sent != exp_crc, !delim} || done_total - d0 != 1) begin
        errors++; $display("FAIL random_%0d_flags: ok/err/derr=%b pulses=%0d want %b/1", n,
                           {crc_ok, crc_err, delim_err}, done_total - d0, {good, sent != exp_crc, !delim});
      end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_delim_err();
    test_gapped();
    test_abort_resync();
    test_reset_mid_frame();
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
